// File: rtl/shot_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : shot_transmitter (with game_pkg)
// Brief    : Latches the cursor on a shoot click and sends it as a 6-byte
//            checksummed frame over a valid/ready byte interface.
// Revision : 1.0 - initial release
// ============================================================================

package game_pkg;
    typedef enum logic [1:0] {
        START     = 2'd0,
        SHOOTER   = 2'd1,
        KEEPER    = 2'd2,
        GAME_OVER = 2'd3
    } g_state;
endpackage

module shot_transmitter #(
    parameter logic [7:0] HEADER          = 8'hA5,
    parameter int         COOLDOWN_CYCLES = 65_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  game_pkg::g_state     game_state,
    input  logic                 left,
    input  logic [11:0]          xpos,
    input  logic [11:0]          ypos,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic                 shot_sent,
    output logic [11:0]          shot_x,
    output logic [11:0]          shot_y
);

    localparam int CW = $clog2(COOLDOWN_CYCLES + 1);
    localparam logic [CW-1:0] c_cool_load = CW'(COOLDOWN_CYCLES);
    localparam logic [CW-1:0] c_cool_one  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_COOL = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_left_d;
    logic [2:0]      r_idx;
    logic [CW-1:0]   r_cnt;
    logic            w_trigger;

    assign w_trigger = left & ~r_left_d & (game_state == game_pkg::SHOOTER)
                     & (r_state == ST_IDLE);

    // Frame content is built from the latched coordinates only.
    function automatic logic [7:0] frame_byte(input logic [2:0] idx,
                                              input logic [11:0] x,
                                              input logic [11:0] y);
        logic [7:0] b1, b2, b3, b4;
        b1 = {4'h0, x[11:8]};
        b2 = x[7:0];
        b3 = {4'h0, y[11:8]};
        b4 = y[7:0];
        case (idx)
            3'd0:    frame_byte = HEADER;
            3'd1:    frame_byte = b1;
            3'd2:    frame_byte = b2;
            3'd3:    frame_byte = b3;
            3'd4:    frame_byte = b4;
            3'd5:    frame_byte = b1 ^ b2 ^ b3 ^ b4;
            default: frame_byte = 8'h00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_left_d  <= 1'b0;
            r_idx     <= 3'd0;
            r_cnt     <= '0;
            tx_data   <= 8'h00;
            tx_valid  <= 1'b0;
            busy      <= 1'b0;
            shot_sent <= 1'b0;
            shot_x    <= 12'h000;
            shot_y    <= 12'h000;
        end else begin
            r_left_d  <= left;
            shot_sent <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_trigger) begin
                        shot_x   <= xpos;
                        shot_y   <= ypos;
                        busy     <= 1'b1;
                        tx_data  <= HEADER;
                        tx_valid <= 1'b1;
                        r_idx    <= 3'd0;
                        r_state  <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (tx_ready) begin
                        if (r_idx == 3'd5) begin
                            tx_valid  <= 1'b0;
                            shot_sent <= 1'b1;
                            r_cnt     <= c_cool_load;
                            r_state   <= ST_COOL;
                        end else begin
                            r_idx   <= r_idx + 3'd1;
                            tx_data <= frame_byte(r_idx + 3'd1, shot_x, shot_y);
                        end
                    end
                end
                ST_COOL: begin
                    // Leaving on the cycle the count hits zero gives exactly
                    // COOLDOWN_CYCLES cycles before a trigger can be taken.
                    r_cnt <= r_cnt - c_cool_one;
                    if (r_cnt <= c_cool_one) begin
                        r_cnt   <= '0;
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_shot_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_shot_transmitter
// Brief    : Self-checking bench: frame vectors, backpressure, gating,
//            busy-ignore, live-coordinate and mid-frame reset sequences.
// Revision : 1.0 - initial release
// ============================================================================

module tb_shot_transmitter;

    localparam int COOL = 10;

    logic              clk = 1'b0;
    logic              rst;
    game_pkg::g_state  game_state;
    logic              left;
    logic [11:0]       xpos, ypos;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;
    logic              shot_sent;
    logic [11:0]       shot_x, shot_y;

    int errors = 0;
    int checks = 0;
    int hs_count = 0;
    int sent_count = 0;

    logic [7:0] exp_q[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always #5 clk = ~clk;

    shot_transmitter #(
        .HEADER          (8'hA5),
        .COOLDOWN_CYCLES (COOL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .game_state (game_state),
        .left       (left),
        .xpos       (xpos),
        .ypos       (ypos),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .shot_sent  (shot_sent),
        .shot_x     (shot_x),
        .shot_y     (shot_y)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted byte must match the head of the queue.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", {31'd0, tx_valid}, 32'd1);
                check("hold_data", {24'd0, tx_data}, {24'd0, prev_data});
            end
            if (tx_valid && tx_ready) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got=%0h expected=none", tx_data);
                end else begin
                    check("frame_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (shot_sent) sent_count++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_frame(input logic [11:0] x, input logic [11:0] y);
        logic [7:0] b1, b2, b3, b4;
        b1 = {4'h0, x[11:8]};
        b2 = x[7:0];
        b3 = {4'h0, y[11:8]};
        b4 = y[7:0];
        exp_q.push_back(8'hA5);
        exp_q.push_back(b1);
        exp_q.push_back(b2);
        exp_q.push_back(b3);
        exp_q.push_back(b4);
        exp_q.push_back(b1 ^ b2 ^ b3 ^ b4);
    endtask

    task automatic press();
        tick(1);
        left = 1'b1;
        tick(1);
        left = 1'b0;
    endtask

    task automatic wait_drain(output int cycles);
        cycles = 0;
        while (exp_q.size() != 0 && cycles < 200) begin
            tick(1);
            cycles++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got=%0d bytes left expected=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (busy && c < 200) begin
            tick(1);
            c++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=1 expected=0");
        end
    endtask

    typedef struct {
        logic [11:0] x;
        logic [11:0] y;
        logic [47:0] bytes;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int cyc, hs0, s0;
        rst = 1'b1;
        game_state = game_pkg::SHOOTER;
        left = 1'b0;
        xpos = 12'h000;
        ypos = 12'h000;
        tx_ready = 1'b1;

        vecs[0] = '{12'h3E8, 12'h1F4, 48'hA5_03_E8_01_F4_1E};
        vecs[1] = '{12'h000, 12'h000, 48'hA5_00_00_00_00_00};
        vecs[2] = '{12'hFFF, 12'hFFF, 48'hA5_0F_FF_0F_FF_00};
        vecs[3] = '{12'h123, 12'hABC, 48'hA5_01_23_0A_BC_94};
        vecs[4] = '{12'hFFF, 12'h000, 48'hA5_0F_FF_00_00_F0};

        tick(3);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_shot_sent", {31'd0, shot_sent}, 32'd0);
        check("rst_shot_xy", {8'd0, shot_x, shot_y}, 32'd0);
        rst = 1'b0;
        tick(2);

        // Table-driven frames with tx_ready high.
        for (int i = 0; i < 5; i++) begin
            xpos = vecs[i].x;
            ypos = vecs[i].y;
            for (int k = 0; k < 6; k++) exp_q.push_back(vecs[i].bytes[47 - 8*k -: 8]);
            s0 = sent_count;
            press();
            check("first_valid", {31'd0, tx_valid}, 32'd1);
            wait_drain(cyc);
            check("frame_cycles", cyc, 32'd6);
            check("shot_sent_hi", {31'd0, shot_sent}, 32'd1);
            check("busy_in_cool", {31'd0, busy}, 32'd1);
            check("shot_x", {20'd0, shot_x}, {20'd0, vecs[i].x});
            check("shot_y", {20'd0, shot_y}, {20'd0, vecs[i].y});
            tick(1);
            check("shot_sent_lo", {31'd0, shot_sent}, 32'd0);
            check("sent_once", sent_count - s0, 32'd1);
            wait_idle();
        end

        // Backpressure: ready low 3 cycles before each byte.
        xpos = 12'h3E8;
        ypos = 12'h1F4;
        tx_ready = 1'b0;
        push_frame(12'h3E8, 12'h1F4);
        hs0 = hs_count;
        press();
        for (int b = 0; b < 6; b++) begin
            tick(3);
            tx_ready = 1'b1;
            tick(1);
            tx_ready = 1'b0;
        end
        wait_drain(cyc);
        check("bp_handshakes", hs_count - hs0, 32'd6);
        tx_ready = 1'b1;
        wait_idle();

        // Gating by game_state and held button.
        game_state = game_pkg::KEEPER;
        tick(1);
        left = 1'b1;
        tick(5);
        check("gate_valid", {31'd0, tx_valid}, 32'd0);
        check("gate_busy", {31'd0, busy}, 32'd0);
        game_state = game_pkg::SHOOTER;
        tick(5);
        check("held_valid", {31'd0, tx_valid}, 32'd0);
        check("held_busy", {31'd0, busy}, 32'd0);
        left = 1'b0;
        tick(1);
        push_frame(12'h3E8, 12'h1F4);
        press();
        wait_drain(cyc);
        check("gate_frame_cycles", cyc, 32'd6);
        wait_idle();

        // Clicks during SEND and COOL are dropped; click right after busy falls works.
        hs0 = hs_count;
        s0 = sent_count;
        push_frame(12'h3E8, 12'h1F4);
        press();
        xpos = 12'h555;
        press();
        wait_drain(cyc);
        check("cool_busy", {31'd0, busy}, 32'd1);
        press();
        wait_idle();
        tick(2);
        check("ignore_handshakes", hs_count - hs0, 32'd6);
        check("ignore_sent", sent_count - s0, 32'd1);
        xpos = 12'h7A1;
        ypos = 12'h0C3;
        wait_idle();
        push_frame(12'h7A1, 12'h0C3);
        press();
        wait_drain(cyc);
        check("refire_x", {20'd0, shot_x}, 32'h7A1);
        check("refire_y", {20'd0, shot_y}, 32'h0C3);
        wait_idle();

        // Live coordinate change mid-frame must not leak into the frame.
        xpos = 12'h3E8;
        ypos = 12'h1F4;
        push_frame(12'h3E8, 12'h1F4);
        press();
        xpos = 12'h000;
        ypos = 12'h000;
        wait_drain(cyc);
        check("live_shot_x", {20'd0, shot_x}, 32'h3E8);
        wait_idle();

        // Reset after byte2 acceptance aborts the frame.
        xpos = 12'h3E8;
        ypos = 12'h1F4;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'hE8);
        press();
        wait_drain(cyc);
        tx_ready = 1'b0;
        rst = 1'b1;
        tick(1);
        check("abort_valid", {31'd0, tx_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_shot_x", {20'd0, shot_x}, 32'd0);
        rst = 1'b0;
        tx_ready = 1'b1;
        tick(2);
        push_frame(12'h3E8, 12'h1F4);
        press();
        check("restart_header", {24'd0, tx_data}, 32'hA5);
        wait_drain(cyc);
        check("restart_cycles", cyc, 32'd6);
        wait_idle();

        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
